// File: rtl/ann_pkg.sv
// Shared definitions for the ANN neuron/layer blocks: data widths, the
// sequencer state type and the accumulator-to-output conversion.
package ann_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC   = 8;
    localparam int unsigned ACC_W  = 40;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StFinal,
        StOut
    } state_e;

    // Drop the fractional bits (floor), then clamp to the signed DATA_W range.
    // With relu set, any negative result becomes zero.
    function automatic logic [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] acc,
                                                    input logic                    relu);
        logic signed [ACC_W-1:0] s;
        logic [DATA_W-1:0]       res;
        s = acc >>> FRAC;
        if (relu && s[ACC_W-1]) begin
            res = '0;
        end else if (s[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){s[ACC_W-1]}}) begin
            // Upper bits are pure sign extension: value fits as-is.
            res = s[DATA_W-1:0];
        end else if (s[ACC_W-1]) begin
            res = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            res = {1'b0, {(DATA_W-1){1'b1}}};
        end
        return res;
    endfunction

endpackage

// File: rtl/ann_mac_pipe.sv
// Two-stage multiply-accumulate: a registered signed product followed by a
// wide accumulator that absorbs the product one cycle after it was loaded.
module ann_mac_pipe
    import ann_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     load_i,
    input  logic signed [DATA_W-1:0] w_i,
    input  logic signed [DATA_W-1:0] x_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] p_q, p_d;
    logic                     p_vld_q, p_vld_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    assign prod  = w_i * x_i;
    assign acc_o = acc_q;

    // Next state: load product on request, fold the previous product into acc.
    always_comb begin
        p_d     = p_q;
        p_vld_d = load_i;
        acc_d   = acc_q;
        if (load_i) begin
            p_d = prod;
        end
        if (p_vld_q) begin
            acc_d = acc_q + {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q};
        end
    end

    // Pipeline registers; clear restarts a fresh dot product.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            p_q     <= '0;
            p_vld_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            p_q     <= p_d;
            p_vld_q <= p_vld_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// Neuron sequencer: walks the weight BRAM, pairs each weight with a streamed
// activation, and hands the saturated dot product out over valid/ready.
module neuron_mac_seq
    import ann_pkg::*;
#(
    parameter int unsigned N_IN   = 28,
    parameter int unsigned ADDR_W = 5,
    parameter bit          RELU   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    input  logic [DATA_W-1:0] x_data_i,
    input  logic              x_valid_i,
    output logic              x_ready_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic              w_en_o,
    input  logic [DATA_W-1:0] w_do_i,
    output logic [DATA_W-1:0] y_data_o,
    output logic              y_valid_o,
    input  logic              y_ready_i
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_IN - 1);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic              w_en_q, w_en_d;
    logic              w_ok_q, w_ok_d;
    logic [DATA_W-1:0] y_data_q, y_data_d;
    logic              y_valid_q, y_valid_d;

    logic                    x_ready;
    logic                    accept;
    logic                    last;
    logic                    clr;
    logic signed [ACC_W-1:0] acc;

    assign accept = x_valid_i && x_ready;
    assign last   = (idx_q == LastIdx);
    assign clr    = (state_q == StIdle) && start_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (accept && last) state_d = StDrain;
            StDrain: state_d = StFinal;
            StFinal: state_d = StOut;
            StOut:   if (y_valid_q && y_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM-derived outputs; an activation is only taken once W_DO matches W_ADDR.
    always_comb begin
        busy_o  = (state_q != StIdle);
        x_ready = (state_q == StRun) && w_ok_q;
    end

    // Address walk, BRAM data-valid tracking and output capture.
    always_comb begin
        idx_d     = idx_q;
        w_addr_d  = w_addr_q;
        w_en_d    = w_en_q;
        w_ok_d    = w_ok_q;
        y_data_d  = y_data_q;
        y_valid_d = y_valid_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    idx_d    = '0;
                    w_addr_d = '0;
                    w_en_d   = 1'b1;
                    w_ok_d   = 1'b0;
                end
            end
            StRun: begin
                if (accept) begin
                    w_ok_d = 1'b0;
                    if (last) begin
                        w_en_d = 1'b0;
                    end else begin
                        idx_d    = idx_q + ADDR_W'(1);
                        w_addr_d = idx_q + ADDR_W'(1);
                    end
                end else if (!w_ok_q) begin
                    // BRAM has now had a negedge to fetch the current address.
                    w_ok_d = 1'b1;
                end
            end
            StFinal: begin
                y_data_d  = sat_shift(acc, RELU);
                y_valid_d = 1'b1;
            end
            StOut: begin
                if (y_ready_i) begin
                    y_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Sequencer datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q     <= '0;
            w_addr_q  <= '0;
            w_en_q    <= 1'b0;
            w_ok_q    <= 1'b0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            w_addr_q  <= w_addr_d;
            w_en_q    <= w_en_d;
            w_ok_q    <= w_ok_d;
            y_data_q  <= y_data_d;
            y_valid_q <= y_valid_d;
        end
    end

    ann_mac_pipe u_mac (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr),
        .load_i (accept),
        .w_i    (w_do_i),
        .x_i    (x_data_i),
        .acc_o  (acc)
    );

    assign x_ready_o = x_ready;
    assign w_addr_o  = w_addr_q;
    assign w_en_o    = w_en_q;
    assign y_data_o  = y_data_q;
    assign y_valid_o = y_valid_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: two instances (RELU=1 and RELU=0) share one
// stimulus stream; each has its own BRAM model fed from the same weights.
module tb_neuron_mac_seq;
    import ann_pkg::*;

    localparam int N = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, x_valid, y_ready;
    logic [15:0] x_data;
    logic        busy0, busy1, xr0, xr1, wen0, wen1, yv0, yv1;
    logic [4:0]  wa0, wa1;
    logic [15:0] wdo0 = '0, wdo1 = '0, y0, y1;

    logic [15:0] w_mem [N];
    logic [15:0] x_mem [N];

    int n_chk = 0;
    int n_fail = 0;

    neuron_mac_seq #(.N_IN(N), .ADDR_W(5), .RELU(1'b1)) u_relu (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy0),
        .x_data_i(x_data), .x_valid_i(x_valid), .x_ready_o(xr0),
        .w_addr_o(wa0), .w_en_o(wen0), .w_do_i(wdo0),
        .y_data_o(y0), .y_valid_o(yv0), .y_ready_i(y_ready)
    );

    neuron_mac_seq #(.N_IN(N), .ADDR_W(5), .RELU(1'b0)) u_lin (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy1),
        .x_data_i(x_data), .x_valid_i(x_valid), .x_ready_o(xr1),
        .w_addr_o(wa1), .w_en_o(wen1), .w_do_i(wdo1),
        .y_data_o(y1), .y_valid_o(yv1), .y_ready_i(y_ready)
    );

    // BRAM models: read on the falling edge.
    always @(negedge clk) if (wen0) wdo0 <= w_mem[wa0];
    always @(negedge clk) if (wen1) wdo1 <= w_mem[wa1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
        end
    endtask

    // Reference: exact dot product, floor-divide by 256, clamp, optional ReLU.
    function automatic logic [15:0] model_y(input bit relu);
        longint sum;
        longint s;
        sum = 0;
        for (int i = 0; i < N; i++)
            sum += longint'($signed(w_mem[i])) * longint'($signed(x_mem[i]));
        s = sum >>> 8;
        if (relu && s < 0) return 16'h0000;
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    logic [15:0] exp_y0 = '0, exp_y1 = '0;
    int  cyc = 0, n_acc = 0, t_start = 0, t_last = 0, t_yv = 0, exp_wa;
    bit  exp_busy = 0, exp_yv, yv0_prev = 0;
    bit  p_acc, p_start, p_rst, p_hs;

    // Per-cycle compare against the transaction-level expectation.
    always begin
        @(posedge clk);
        cyc++;
        p_acc   = x_valid && xr0;
        p_start = start && !busy0;
        p_rst   = rst;
        p_hs    = yv0 && y_ready;
        #1;
        if (p_rst) begin
            n_acc    = 0;
            exp_busy = 0;
            chk("rst_busy0", busy0, 0);  chk("rst_busy1", busy1, 0);
            chk("rst_xr0", xr0, 0);      chk("rst_xr1", xr1, 0);
            chk("rst_wa0", wa0, 0);      chk("rst_wa1", wa1, 0);
            chk("rst_wen0", wen0, 0);    chk("rst_wen1", wen1, 0);
            chk("rst_yv0", yv0, 0);      chk("rst_yv1", yv1, 0);
            chk("rst_y0", y0, 0);        chk("rst_y1", y1, 0);
        end else begin
            if (p_start) begin
                n_acc    = 0;
                exp_busy = 1;
                t_start  = cyc;
            end else if (p_acc) begin
                n_acc++;
                if (n_acc == N) t_last = cyc;
            end
            if (p_hs) exp_busy = 0;
            exp_wa = (n_acc >= N) ? N - 1 : n_acc;
            exp_yv = exp_busy && n_acc == N && cyc >= t_last + 2;
            chk("busy0", busy0, exp_busy);  chk("busy1", busy1, exp_busy);
            chk("w_addr0", wa0, exp_wa);    chk("w_addr1", wa1, exp_wa);
            chk("w_en0", wen0, exp_busy && n_acc < N);
            chk("w_en1", wen1, exp_busy && n_acc < N);
            chk("y_valid0", yv0, exp_yv);   chk("y_valid1", yv1, exp_yv);
            if (!exp_busy || n_acc >= N) begin
                chk("x_ready0_low", xr0, 0);
                chk("x_ready1_low", xr1, 0);
            end
            if (exp_yv) begin
                chk("y_data0", y0, exp_y0);
                chk("y_data1", y1, exp_y1);
            end
        end
        if (yv0 && !yv0_prev) t_yv = cyc;
        yv0_prev = yv0;
    end

    logic [15:0] res0, res1;
    bit ok;

    // Called at a negedge; starts immediately and returns at a negedge.
    task automatic run_neuron(input int gap_max, input int ylow, input int start_at,
                              input int rst_at, output bit done);
        int cnt;
        int gap;
        done    = 0;
        exp_y0  = model_y(1);
        exp_y1  = model_y(0);
        y_ready = (ylow == 0);
        start   = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < N; i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (gap) @(negedge clk);
            if (i == start_at) begin
                start = 1;
                @(negedge clk);
                start = 0;
            end
            x_valid = 1;
            x_data  = x_mem[i];
            cnt = 0;
            while (!xr0 && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            chk("x_ready_wait", xr0, 1);
            if (!xr0) begin
                x_valid = 0;
                return;
            end
            @(negedge clk);
            x_valid = 0;
            x_data  = 16'($urandom);
            if (i == rst_at) begin
                rst = 1;
                @(negedge clk);
                chk("mid_rst_busy", busy0, 0);
                chk("mid_rst_wen", wen0, 0);
                chk("mid_rst_waddr", wa0, 0);
                chk("mid_rst_yvalid", yv1, 0);
                chk("mid_rst_ydata", y1, 0);
                rst = 0;
                return;
            end
        end
        cnt = 0;
        while (!yv0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("y_valid_wait", yv0, 1);
        res0 = y0;
        res1 = y1;
        if (ylow > 0) begin
            repeat (ylow) @(negedge clk);
            chk("hold_yvalid", yv1, 1);
            chk("hold_ydata", y1, res1);
            y_ready = 1;
        end
        @(negedge clk);
        done = 1;
    endtask

    task automatic fill(input logic [15:0] w, input logic [15:0] x);
        for (int i = 0; i < N; i++) begin
            w_mem[i] = w;
            x_mem[i] = x;
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1; start = 0; x_valid = 0; x_data = '0; y_ready = 1;
        fill(16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        rst = 0;

        // Unity: 28 x 1.0 x 1.0 = 28.0
        fill(16'h0100, 16'h0100);
        chk("model_unity", model_y(0), 16'h1C00);
        run_neuron(0, 0, -1, -1, ok);
        chk("unity_relu", res0, 16'h1C00);
        chk("unity_lin", res1, 16'h1C00);
        chk("unity_latency", t_yv - t_start + 1, 59);

        // Negative, started in the cycle right after the handshake.
        fill(16'h0100, 16'hFF00);
        chk("model_neg", model_y(0), 16'hE400);
        run_neuron(0, 0, -1, -1, ok);
        chk("neg_relu", res0, 16'h0000);
        chk("neg_lin", res1, 16'hE400);

        // Saturation both ways.
        fill(16'h7FFF, 16'h7FFF);
        run_neuron(0, 0, -1, -1, ok);
        chk("sat_pos_relu", res0, 16'h7FFF);
        chk("sat_pos_lin", res1, 16'h7FFF);
        fill(16'h7FFF, 16'h8000);
        run_neuron(0, 0, -1, -1, ok);
        chk("sat_neg_relu", res0, 16'h0000);
        chk("sat_neg_lin", res1, 16'h8000);

        // Activation gaps plus consumer stall.
        fill(16'h0100, 16'h0100);
        run_neuron(3, 5, -1, -1, ok);
        chk("bp_lin", res1, 16'h1C00);

        // Spurious START while running.
        run_neuron(1, 0, 5, -1, ok);
        chk("start_in_run", res1, 16'h1C00);

        // Reset after element 10, then a clean run.
        run_neuron(0, 0, -1, 10, ok);
        chk("rst_aborted", ok, 0);
        run_neuron(0, 0, -1, -1, ok);
        chk("after_rst", res1, 16'h1C00);

        // Ramp: the sum is 189.0, beyond the Q8.8 range, so it saturates.
        for (int i = 0; i < N; i++) begin
            w_mem[i] = 16'(i * 256);
            x_mem[i] = 16'h0080;
        end
        chk("model_ramp", model_y(0), 16'h7FFF);
        run_neuron(0, 0, -1, -1, ok);
        chk("ramp_lin", res1, 16'h7FFF);

        // Random weights/activations, gaps and stalls.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) begin
                if (t[0]) begin
                    w_mem[i] = 16'($urandom);
                    x_mem[i] = 16'($urandom);
                end else begin
                    w_mem[i] = 16'(int'($urandom_range(0, 1023)) - 512);
                    x_mem[i] = 16'(int'($urandom_range(0, 1023)) - 512);
                end
            end
            run_neuron(2, int'($urandom_range(0, 4)), -1, -1, ok);
            chk("rand_relu", res0, model_y(1));
            chk("rand_lin", res1, model_y(0));
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
